// File: rtl/exe_stage_mc.sv
// exe_stage_mc: execute stage with registered outputs.
// Single-cycle ALU ops and branch resolution, plus an optional iterative
// unsigned MUL/DIV/REM unit that retires one bit per cycle.
// Optional feature macro: EXE_MDU_EN (defined = iterative multiply/divide unit,
// undefined = codes 1100-1110 complete in one cycle with result 0, busy tied 0).
module exe_stage_mc #(
   parameter int XLEN     = 32,
   parameter int BR_SHIFT = 2
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            in_valid,
   input  logic            flush,
   input  logic [3:0]      exe_cmd,
   input  logic [XLEN-1:0] val1,
   input  logic [XLEN-1:0] val2,
   input  logic [XLEN-1:0] val_src2,
   input  logic [XLEN-1:0] pc,
   input  logic [1:0]      br_type,
   output logic            out_valid,
   output logic [XLEN-1:0] alu_result,
   output logic [XLEN-1:0] br_addr,
   output logic            br_taken,
   output logic            busy
);

   localparam int CW = $clog2(XLEN);

   localparam logic [3:0] CMD_ADD = 4'b0000;
   localparam logic [3:0] CMD_SUB = 4'b0010;
   localparam logic [3:0] CMD_AND = 4'b0100;
   localparam logic [3:0] CMD_OR  = 4'b0101;
   localparam logic [3:0] CMD_NOR = 4'b0110;
   localparam logic [3:0] CMD_XOR = 4'b0111;
   localparam logic [3:0] CMD_SLL = 4'b1001;
   localparam logic [3:0] CMD_SRA = 4'b1010;
   localparam logic [3:0] CMD_SRL = 4'b1011;

   logic [CW-1:0]   shamt;
   logic [XLEN-1:0] sc_result;
   logic [XLEN-1:0] sc_br_addr;
   logic            sc_br_taken;

   // Single-cycle ALU result and branch resolution from the live operands.
   always_comb begin
      shamt       = val2[CW-1:0];
      sc_result   = '0;
      sc_br_addr  = pc + (val2 << BR_SHIFT);
      sc_br_taken = 1'b0;
      case (exe_cmd)
         CMD_ADD: sc_result = val1 + val2;
         CMD_SUB: sc_result = val1 - val2;
         CMD_AND: sc_result = val1 & val2;
         CMD_OR:  sc_result = val1 | val2;
         CMD_NOR: sc_result = ~(val1 | val2);
         CMD_XOR: sc_result = val1 ^ val2;
         CMD_SLL: sc_result = val1 << shamt;
         CMD_SRA: sc_result = $unsigned($signed(val1) >>> shamt);
         CMD_SRL: sc_result = val1 >> shamt;
         default: sc_result = '0;
      endcase
      case (br_type)
         2'b01:   sc_br_taken = (val1 == '0);
         2'b10:   sc_br_taken = (val1 != val_src2);
         2'b11:   sc_br_taken = 1'b1;
         default: sc_br_taken = 1'b0;
      endcase
   end

`ifdef EXE_MDU_EN

   typedef enum logic [1:0] {
      S_IDLE,
      S_RUN,
      S_DONE
   } state_t;

   localparam logic [1:0] OP_MUL = 2'b00;
   localparam logic [1:0] OP_DIV = 2'b01;

   state_t          state_q, state_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [1:0]      op_q, op_d;
   logic [XLEN-1:0] a_q, a_d;
   logic [XLEN-1:0] b_q, b_d;
   logic [XLEN-1:0] acc_q, acc_d;
   logic            out_valid_q, out_valid_d;
   logic [XLEN-1:0] result_q, result_d;
   logic [XLEN-1:0] br_addr_q, br_addr_d;
   logic            br_taken_q, br_taken_d;
   logic            busy_q, busy_d;

   logic            accept;
   logic            is_mdu_cmd;
   logic [XLEN-1:0] mul_acc;
   logic [XLEN:0]   div_shift;
   logic            div_ge;
   logic [XLEN-1:0] div_rem;
   logic [XLEN-1:0] div_quo;

   // One shift-add (multiply) or restoring (divide) step on the latched operands.
   // a_q holds the multiplicand / the dividend shifting into the quotient,
   // b_q holds the multiplier / the divisor, acc_q the product / partial remainder.
   // A zero divisor naturally yields an all-ones quotient and remainder = dividend.
   always_comb begin
      accept     = in_valid & ~busy_q & ~flush;
      is_mdu_cmd = (exe_cmd == 4'b1100) || (exe_cmd == 4'b1101) || (exe_cmd == 4'b1110);
      mul_acc    = b_q[0] ? (acc_q + a_q) : acc_q;
      div_shift  = {acc_q, a_q[XLEN-1]};
      div_ge     = (div_shift >= {1'b0, b_q});
      div_rem    = div_ge ? (div_shift[XLEN-1:0] - b_q) : div_shift[XLEN-1:0];
      div_quo    = {a_q[XLEN-2:0], div_ge};
   end

   // Next-state logic for the IDLE/RUN/DONE sequencer and all registered outputs.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      op_d        = op_q;
      a_d         = a_q;
      b_d         = b_q;
      acc_d       = acc_q;
      out_valid_d = 1'b0;
      result_d    = result_q;
      br_addr_d   = br_addr_q;
      br_taken_d  = br_taken_q;
      busy_d      = busy_q;
      case (state_q)
         S_IDLE: begin
            if (accept) begin
               br_addr_d = sc_br_addr;
               if (is_mdu_cmd) begin
                  state_d    = S_RUN;
                  cnt_d      = '0;
                  op_d       = exe_cmd[1:0];
                  a_d        = val1;
                  b_d        = val2;
                  acc_d      = '0;
                  br_taken_d = 1'b0;
                  busy_d     = 1'b1;
               end else begin
                  out_valid_d = 1'b1;
                  result_d    = sc_result;
                  br_taken_d  = sc_br_taken;
               end
            end
         end
         S_RUN: begin
            cnt_d = cnt_q + CW'(1);
            if (op_q == OP_MUL) begin
               acc_d = mul_acc;
               a_d   = a_q << 1;
               b_d   = b_q >> 1;
            end else begin
               acc_d = div_rem;
               a_d   = div_quo;
            end
            if (cnt_q == CW'(XLEN - 1)) begin
               state_d     = S_DONE;
               out_valid_d = 1'b1;
               if (op_q == OP_MUL) begin
                  result_d = mul_acc;
               end else if (op_q == OP_DIV) begin
                  result_d = div_quo;
               end else begin
                  result_d = div_rem;
               end
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
            busy_d  = 1'b0;
         end
         default: begin
            state_d = S_IDLE;
            busy_d  = 1'b0;
         end
      endcase
      if (flush) begin
         state_d     = S_IDLE;
         busy_d      = 1'b0;
         out_valid_d = 1'b0;
         result_d    = result_q;
         br_addr_d   = br_addr_q;
         br_taken_d  = br_taken_q;
      end
   end

   // Sequencer state, datapath and output registers; async active-low clear.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= S_IDLE;
         cnt_q       <= '0;
         op_q        <= '0;
         a_q         <= '0;
         b_q         <= '0;
         acc_q       <= '0;
         out_valid_q <= 1'b0;
         result_q    <= '0;
         br_addr_q   <= '0;
         br_taken_q  <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         op_q        <= op_d;
         a_q         <= a_d;
         b_q         <= b_d;
         acc_q       <= acc_d;
         out_valid_q <= out_valid_d;
         result_q    <= result_d;
         br_addr_q   <= br_addr_d;
         br_taken_q  <= br_taken_d;
         busy_q      <= busy_d;
      end
   end

   assign busy = busy_q;

`else

   logic            out_valid_q, out_valid_d;
   logic [XLEN-1:0] result_q, result_d;
   logic [XLEN-1:0] br_addr_q, br_addr_d;
   logic            br_taken_q, br_taken_d;
   logic            accept;

   // Without the multiply/divide unit every op, including 1100-1110, retires next cycle.
   always_comb begin
      accept      = in_valid & ~flush;
      out_valid_d = accept;
      result_d    = result_q;
      br_addr_d   = br_addr_q;
      br_taken_d  = br_taken_q;
      if (accept) begin
         result_d   = sc_result;
         br_addr_d  = sc_br_addr;
         br_taken_d = sc_br_taken;
      end
   end

   // Output registers; async active-low clear.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         out_valid_q <= 1'b0;
         result_q    <= '0;
         br_addr_q   <= '0;
         br_taken_q  <= 1'b0;
      end else begin
         out_valid_q <= out_valid_d;
         result_q    <= result_d;
         br_addr_q   <= br_addr_d;
         br_taken_q  <= br_taken_d;
      end
   end

   assign busy = 1'b0;

`endif

   assign out_valid  = out_valid_q;
   assign alu_result = result_q;
   assign br_addr    = br_addr_q;
   assign br_taken   = br_taken_q;

endmodule

// File: tb/tb_exe_stage_mc.sv
// tb_exe_stage_mc: self-checking bench for exe_stage_mc.
// Expected values come from arithmetic reference functions below; MDU timing
// expectations follow the documented latency (busy for XLEN+1 cycles).
module tb_exe_stage_mc;

   localparam int XLEN     = 32;
   localparam int BR_SHIFT = 2;

   localparam logic [3:0] C_ADD = 4'b0000;
   localparam logic [3:0] C_MUL = 4'b1100;
   localparam logic [3:0] C_DIV = 4'b1101;
   localparam logic [3:0] C_REM = 4'b1110;

   logic            clk = 1'b0;
   logic            rst = 1'b0;
   logic            in_valid = 1'b0;
   logic            flush = 1'b0;
   logic [3:0]      exe_cmd = '0;
   logic [XLEN-1:0] val1 = '0;
   logic [XLEN-1:0] val2 = '0;
   logic [XLEN-1:0] val_src2 = '0;
   logic [XLEN-1:0] pc = '0;
   logic [1:0]      br_type = '0;
   logic            out_valid;
   logic [XLEN-1:0] alu_result;
   logic [XLEN-1:0] br_addr;
   logic            br_taken;
   logic            busy;

   int n_cmp  = 0;
   int n_fail = 0;

   exe_stage_mc #(.XLEN(XLEN), .BR_SHIFT(BR_SHIFT)) dut (
      .clk        (clk),
      .rst        (rst),
      .in_valid   (in_valid),
      .flush      (flush),
      .exe_cmd    (exe_cmd),
      .val1       (val1),
      .val2       (val2),
      .val_src2   (val_src2),
      .pc         (pc),
      .br_type    (br_type),
      .out_valid  (out_valid),
      .alu_result (alu_result),
      .br_addr    (br_addr),
      .br_taken   (br_taken),
      .busy       (busy)
   );

   always #5 clk = ~clk;

   // Reference result computed from the operation's arithmetic meaning.
   function automatic logic [XLEN-1:0] model_result(input logic [3:0] cmd,
                                                    input logic [XLEN-1:0] a,
                                                    input logic [XLEN-1:0] b);
      int sh;
      logic [XLEN-1:0] r;
      sh = int'(b % XLEN);
      case (cmd)
         4'b0000: r = a + b;
         4'b0010: r = a - b;
         4'b0100: r = a & b;
         4'b0101: r = a | b;
         4'b0110: r = ~(a | b);
         4'b0111: r = a ^ b;
         4'b1001: r = a << sh;
         4'b1011: r = a >> sh;
         4'b1010: r = (a >> sh) | (a[XLEN-1] ? ~({XLEN{1'b1}} >> sh) : '0);
`ifdef EXE_MDU_EN
         4'b1100: r = a * b;
         4'b1101: r = (b == '0) ? '1 : a / b;
         4'b1110: r = (b == '0) ? a : a % b;
`endif
         default: r = '0;
      endcase
      return r;
   endfunction

   function automatic logic model_taken(input logic [1:0] bt, input logic [XLEN-1:0] a,
                                        input logic [XLEN-1:0] s);
      case (bt)
         2'b01:   return a == '0;
         2'b10:   return a != s;
         2'b11:   return 1'b1;
         default: return 1'b0;
      endcase
   endfunction

   function automatic logic [XLEN-1:0] model_addr(input logic [XLEN-1:0] p, input logic [XLEN-1:0] off);
      logic [XLEN-1:0] r;
      r = p + off * (2 ** BR_SHIFT);
      return r;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [3:0] cmd, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                        input logic [XLEN-1:0] s, input logic [XLEN-1:0] p, input logic [1:0] bt);
      exe_cmd = cmd; val1 = a; val2 = b; val_src2 = s; pc = p; br_type = bt; in_valid = 1'b1;
   endtask

   task automatic test_reset();
      rst = 1'b0;
      tick(); tick();
      n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_out_valid got %0b want 0", out_valid); end
      n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_busy got %0b want 0", busy); end
      n_cmp++; if (alu_result !== '0) begin n_fail++; $display("[TB] FAIL reset_result got %h want 0", alu_result); end
      n_cmp++; if (br_addr !== '0) begin n_fail++; $display("[TB] FAIL reset_br_addr got %h want 0", br_addr); end
      n_cmp++; if (br_taken !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_br_taken got %0b want 0", br_taken); end
      #3 rst = 1'b1;
      tick();
   endtask

   task automatic test_directed();
      drive(C_ADD, 5, 7, 0, 32'h40, 2'b00);
      tick();
      in_valid = 1'b0;
      n_cmp++; if (out_valid !== 1'b1) begin n_fail++; $display("[TB] FAIL add_valid got %0b want 1", out_valid); end
      n_cmp++; if (alu_result !== 32'd12) begin n_fail++; $display("[TB] FAIL add_result got %0d want 12", alu_result); end
      n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("[TB] FAIL add_busy got %0b want 0", busy); end
      tick();
      n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL add_pulse got %0b want 0", out_valid); end
      drive(C_ADD, 3, 3, 4, 32'h100, 2'b10);
      tick();
      n_cmp++; if (br_taken !== 1'b1) begin n_fail++; $display("[TB] FAIL bne_taken got %0b want 1", br_taken); end
      n_cmp++; if (br_addr !== 32'h10C) begin n_fail++; $display("[TB] FAIL bne_addr got %h want 10c", br_addr); end
      drive(C_ADD, 1, 3, 4, 32'h100, 2'b01);
      tick();
      in_valid = 1'b0;
      n_cmp++; if (br_taken !== 1'b0) begin n_fail++; $display("[TB] FAIL bez_taken got %0b want 0", br_taken); end
      n_cmp++; if (out_valid !== 1'b1) begin n_fail++; $display("[TB] FAIL bez_valid got %0b want 1", out_valid); end
      tick();
   endtask

   // Back-to-back random single-cycle ops, one accepted every cycle.
   task automatic test_alu_random();
      logic [3:0] codes [13] = '{4'b0000, 4'b0010, 4'b0100, 4'b0101, 4'b0110, 4'b0111,
                                 4'b1001, 4'b1010, 4'b1011, 4'b0001, 4'b0011, 4'b1000, 4'b1111};
      logic [XLEN-1:0] a, b, s, p, er, ea;
      logic [3:0] cmd;
      logic [1:0] bt;
      logic et;
      for (int i = 0; i < 40; i++) begin
         cmd = codes[$urandom_range(12)];
         a = $urandom; b = $urandom; p = $urandom; bt = 2'($urandom_range(3));
         s = ($urandom_range(1) == 0) ? a : $urandom;
         if ($urandom_range(3) == 0) a = '0;
         er = model_result(cmd, a, b); et = model_taken(bt, a, s); ea = model_addr(p, b);
         drive(cmd, a, b, s, p, bt);
         tick();
         n_cmp++; if (out_valid !== 1'b1 || busy !== 1'b0) begin n_fail++; $display("[TB] FAIL rnd_valid[%0d] got v=%0b b=%0b want v=1 b=0", i, out_valid, busy); end
         n_cmp++; if (alu_result !== er) begin n_fail++; $display("[TB] FAIL rnd_result[%0d] cmd=%b got %h want %h", i, cmd, alu_result, er); end
         n_cmp++; if (br_taken !== et) begin n_fail++; $display("[TB] FAIL rnd_taken[%0d] got %0b want %0b", i, br_taken, et); end
         n_cmp++; if (br_addr !== ea) begin n_fail++; $display("[TB] FAIL rnd_addr[%0d] got %h want %h", i, br_addr, ea); end
      end
      in_valid = 1'b0;
      tick();
      n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL rnd_idle got %0b want 0", out_valid); end
   endtask

   // One MUL/DIV/REM with full latency checking while garbage is offered on the inputs.
   task automatic run_mdu(input logic [3:0] cmd, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b);
      logic [XLEN-1:0] er, ea, p;
      p = $urandom;
      er = model_result(cmd, a, b); ea = model_addr(p, b);
      drive(cmd, a, b, $urandom, p, 2'b11);
      tick();
`ifdef EXE_MDU_EN
      drive(C_ADD, $urandom, $urandom, $urandom, $urandom, 2'b11);
      for (int j = 1; j <= XLEN + 1; j++) begin
         if (j > 1) tick();
         n_cmp++; if (busy !== 1'b1) begin n_fail++; $display("[TB] FAIL mdu_busy cyc=%0d got %0b want 1", j, busy); end
         n_cmp++; if (out_valid !== (j == XLEN + 1)) begin n_fail++; $display("[TB] FAIL mdu_valid cyc=%0d got %0b want %0b", j, out_valid, (j == XLEN + 1)); end
      end
      in_valid = 1'b0;
      n_cmp++; if (alu_result !== er) begin n_fail++; $display("[TB] FAIL mdu_result cmd=%b a=%h b=%h got %h want %h", cmd, a, b, alu_result, er); end
      n_cmp++; if (br_taken !== 1'b0) begin n_fail++; $display("[TB] FAIL mdu_taken got %0b want 0", br_taken); end
      n_cmp++; if (br_addr !== ea) begin n_fail++; $display("[TB] FAIL mdu_addr got %h want %h", br_addr, ea); end
      tick();
      n_cmp++; if (busy !== 1'b0 || out_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL mdu_end got b=%0b v=%0b want 0 0", busy, out_valid); end
`else
      in_valid = 1'b0;
      n_cmp++; if (out_valid !== 1'b1 || busy !== 1'b0) begin n_fail++; $display("[TB] FAIL nomdu_valid got v=%0b b=%0b want 1 0", out_valid, busy); end
      n_cmp++; if (alu_result !== er) begin n_fail++; $display("[TB] FAIL nomdu_result got %h want %h", alu_result, er); end
      n_cmp++; if (br_addr !== ea) begin n_fail++; $display("[TB] FAIL nomdu_addr got %h want %h", br_addr, ea); end
      tick();
      n_cmp++; if (busy !== 1'b0 || out_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL nomdu_end got b=%0b v=%0b want 0 0", busy, out_valid); end
`endif
   endtask

   task automatic test_mdu();
      logic [3:0] cmds [3] = '{C_MUL, C_DIV, C_REM};
      logic [XLEN-1:0] b;
      run_mdu(C_MUL, 1000, 1000);
      run_mdu(C_DIV, 100, 7);
      run_mdu(C_REM, 100, 7);
      run_mdu(C_DIV, 5, 0);
      run_mdu(C_REM, 9, 0);
      for (int i = 0; i < 10; i++) begin
         case ($urandom_range(2))
            0: b = '0;
            1: b = $urandom_range(255);
            default: b = $urandom;
         endcase
         run_mdu(cmds[$urandom_range(2)], $urandom, b);
      end
   endtask

   // Back-to-back: an op offered in the cycle busy drops is accepted immediately.
   task automatic test_back_to_back();
      drive(C_MUL, 6, 7, 0, 0, 2'b00);
      tick();
      in_valid = 1'b0;
`ifdef EXE_MDU_EN
      for (int j = 2; j <= XLEN + 2; j++) tick();
      n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("[TB] FAIL b2b_busy got %0b want 0", busy); end
`endif
      drive(C_ADD, 20, 22, 0, 0, 2'b00);
      tick();
      in_valid = 1'b0;
      n_cmp++; if (out_valid !== 1'b1 || alu_result !== 32'd42) begin n_fail++; $display("[TB] FAIL b2b_add got v=%0b r=%0d want 1 42", out_valid, alu_result); end
      tick();
   endtask

   task automatic test_flush();
      int seen;
      drive(C_ADD, 100, 23, 0, 0, 2'b00);
      flush = 1'b1;
      tick();
      in_valid = 1'b0; flush = 1'b0;
      n_cmp++; if (out_valid !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("[TB] FAIL flush_same_cycle got v=%0b b=%0b want 0 0", out_valid, busy); end
      drive(C_ADD, 100, 23, 0, 0, 2'b00);
      tick();
      in_valid = 1'b0;
      n_cmp++; if (alu_result !== 32'd123) begin n_fail++; $display("[TB] FAIL flush_pre got %0d want 123", alu_result); end
`ifdef EXE_MDU_EN
      drive(C_DIV, 1000, 3, 0, 0, 2'b00);
      tick();
      in_valid = 1'b0;
      for (int j = 2; j <= 10; j++) tick();
      flush = 1'b1;
      tick();
      flush = 1'b0;
      n_cmp++; if (busy !== 1'b0 || out_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL flush_run got b=%0b v=%0b want 0 0", busy, out_valid); end
      n_cmp++; if (alu_result !== 32'd123) begin n_fail++; $display("[TB] FAIL flush_hold got %0d want 123", alu_result); end
      seen = 0;
      for (int j = 0; j < XLEN + 4; j++) begin
         tick();
         if (out_valid !== 1'b0 || busy !== 1'b0) seen++;
      end
      n_cmp++; if (seen != 0) begin n_fail++; $display("[TB] FAIL flush_no_pulse got %0d active cycles want 0", seen); end
`endif
      drive(C_ADD, 8, 9, 0, 0, 2'b00);
      tick();
      in_valid = 1'b0;
      n_cmp++; if (out_valid !== 1'b1 || alu_result !== 32'd17) begin n_fail++; $display("[TB] FAIL flush_after got v=%0b r=%0d want 1 17", out_valid, alu_result); end
      tick();
   endtask

   task automatic test_async_reset();
      drive(C_ADD, 32'h55, 32'h11, 0, 32'h200, 2'b11);
      tick();
      drive(C_MUL, 1234, 5678, 0, 32'h300, 2'b11);
      tick();
      in_valid = 1'b0;
      for (int j = 0; j < 4; j++) tick();
`ifdef EXE_MDU_EN
      n_cmp++; if (busy !== 1'b1) begin n_fail++; $display("[TB] FAIL arst_pre_busy got %0b want 1", busy); end
`endif
      #2 rst = 1'b0;
      #1;
      n_cmp++; if (out_valid !== 1'b0 || busy !== 1'b0 || br_taken !== 1'b0) begin n_fail++; $display("[TB] FAIL arst_ctrl got v=%0b b=%0b t=%0b want 0 0 0", out_valid, busy, br_taken); end
      n_cmp++; if (alu_result !== '0 || br_addr !== '0) begin n_fail++; $display("[TB] FAIL arst_data got r=%h a=%h want 0 0", alu_result, br_addr); end
      #2 rst = 1'b1;
      tick();
      drive(C_ADD, 1, 1, 0, 0, 2'b00);
      tick();
      in_valid = 1'b0;
      n_cmp++; if (out_valid !== 1'b1 || alu_result !== 32'd2) begin n_fail++; $display("[TB] FAIL arst_add got v=%0b r=%0d want 1 2", out_valid, alu_result); end
      tick();
   endtask

   // Scenario sequence.
   initial begin
      $display("[TB] start");
      test_reset();
      test_directed();
      test_alu_random();
      test_mdu();
      test_back_to_back();
      test_flush();
      test_async_reset();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
